// File: rtl/di_pkg.sv
// Shared widths and state encoding for the line prefetcher and its line FIFO.
package di_pkg;

  localparam int DI_LINE_W      = 128;
  localparam int DI_HW_PER_LINE = 8;
  localparam int DI_HW_W        = 16;
  localparam int DI_LADDR_W     = 28;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } di_state_e;

endpackage

// File: rtl/di_line_fifo.sv
// Line FIFO for the prefetcher: DEPTH x 128-bit lines, head and head+1 read ports,
// plus the 16B-line address of the head, which advances on every pop.
module di_line_fifo
  import di_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [DI_LADDR_W-1:0] RST_LADDR = '0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DI_LADDR_W-1:0] flush_laddr,
  input  logic                  push,
  input  logic [DI_LINE_W-1:0]  push_data,
  input  logic                  pop,
  output logic [DI_LINE_W-1:0]  head_data,
  output logic                  head_valid,
  output logic [DI_LINE_W-1:0]  nxt_data,
  output logic                  nxt_valid,
  output logic [DI_LADDR_W-1:0] head_laddr,
  output logic [CNT_W-1:0]      count
);

  logic [DI_LINE_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_nxt_ptr;
  logic [CNT_W-1:0]      cnt_q;
  logic [DI_LADDR_W-1:0] laddr_q;
  logic                  do_pop;

  assign do_pop     = pop && (cnt_q != '0);
  assign rd_nxt_ptr = rd_ptr_q + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      laddr_q  <= RST_LADDR;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      laddr_q  <= flush_laddr;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_nxt_ptr;
        laddr_q  <= laddr_q + DI_LADDR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Data storage carries no reset; invalid entries are masked on the read side.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (cnt_q >= CNT_W'(1));
  assign nxt_valid  = (cnt_q >= CNT_W'(2));
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign nxt_data   = nxt_valid ? mem_q[rd_nxt_ptr] : '0;
  assign head_laddr = laddr_q;
  assign count      = cnt_q;

  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/di_line_prefetcher.sv
// Instruction line prefetcher: streams 16B lines into a small FIFO and presents
// the head/next lines as one halfword-merged view to the issue fetchers.
//
// state    | meaning
// ST_RUN   | requests issued, responses pushed into the line FIFO
// ST_DRAIN | after a redirect with requests in flight: no requests, responses dropped
module di_line_prefetcher
  import di_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_i,
  input  logic [31:0]          branch_addr_i,
  output logic                 instr_req_o,
  output logic [31:0]          instr_addr_o,
  input  logic                 instr_gnt_i,
  input  logic                 instr_rvalid_i,
  input  logic [DI_LINE_W-1:0] instr_rdata_i,
  output logic [DI_LINE_W-1:0] instr_buf_o,
  output logic [2:0]           pi_hw_idx_o,
  output logic                 pi_hw_idx_valid_o,
  output logic [31:0]          pi_fetch_addr_o,
  input  logic                 advance_i,
  input  logic [2:0]           next_hw_idx_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  di_state_e             state_q, state_d;
  logic [DI_LADDR_W-1:0] req_laddr_q;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic [2:0]            hw_idx_q;

  logic [DI_LINE_W-1:0]  head_data, nxt_data;
  logic                  head_valid, nxt_valid;
  logic [DI_LADDR_W-1:0] head_laddr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic gnt_acc, rsp, push, adv_ok, wrap, room_ok, unused_bits;

  assign unused_bits = branch_addr_i[0];

  assign gnt_acc = instr_req_o && instr_gnt_i;
  // Responses with nothing in flight belong to requests from before reset.
  assign rsp     = instr_rvalid_i && (outst_q != '0);
  assign outst_d = outst_q + OUT_W'(gnt_acc) - OUT_W'(rsp);
  assign push    = rsp && (state_q == ST_RUN) && !branch_i;
  assign room_ok = (SUM_W'(fifo_cnt) + SUM_W'(outst_q)) < SUM_W'(DEPTH);

  // A 32-bit instruction starting at halfword 7 needs the next line as well.
  assign pi_hw_idx_valid_o = head_valid &&
    !((hw_idx_q == 3'd7) && (head_data[DI_LINE_W-DI_HW_W +: 2] == 2'b11) && !nxt_valid);

  assign adv_ok = advance_i && pi_hw_idx_valid_o && !branch_i;
  assign wrap   = adv_ok && (next_hw_idx_i < hw_idx_q);

  always_comb begin
    state_d     = state_q;
    instr_req_o = 1'b0;
    if (!rst && (state_q == ST_RUN) && room_ok && (outst_q < OUT_W'(MAX_OUTST)))
      instr_req_o = 1'b1;
    if (branch_i)
      state_d = (outst_d != '0) ? ST_DRAIN : ST_RUN;
    else if ((state_q == ST_DRAIN) && (outst_q == '0))
      state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      outst_q     <= '0;
      req_laddr_q <= BOOT_ADDR[31:4];
      hw_idx_q    <= BOOT_ADDR[3:1];
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (branch_i) begin
        req_laddr_q <= branch_addr_i[31:4];
        hw_idx_q    <= branch_addr_i[3:1];
      end else begin
        if (gnt_acc) req_laddr_q <= req_laddr_q + DI_LADDR_W'(1);
        if (adv_ok)  hw_idx_q    <= next_hw_idx_i;
      end
    end
  end

  di_line_fifo #(
    .DEPTH     (DEPTH),
    .RST_LADDR (BOOT_ADDR[31:4])
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (branch_i),
    .flush_laddr (branch_addr_i[31:4]),
    .push        (push),
    .push_data   (instr_rdata_i),
    .pop         (wrap),
    .head_data   (head_data),
    .head_valid  (head_valid),
    .nxt_data    (nxt_data),
    .nxt_valid   (nxt_valid),
    .head_laddr  (head_laddr),
    .count       (fifo_cnt)
  );

  // Halfwords below the primary index already belong to the following line.
  always_comb begin
    instr_buf_o = '0;
    for (int k = 0; k < DI_HW_PER_LINE; k++) begin
      instr_buf_o[k*DI_HW_W +: DI_HW_W] = (3'(k) >= hw_idx_q) ?
        head_data[k*DI_HW_W +: DI_HW_W] : nxt_data[k*DI_HW_W +: DI_HW_W];
    end
  end

  assign instr_addr_o    = {req_laddr_q, 4'b0000};
  assign pi_hw_idx_o     = hw_idx_q;
  assign pi_fetch_addr_o = {head_laddr, hw_idx_q, 1'b0};

endmodule

// File: doc/di_line_prefetcher.md
DI_LINE_PREFETCHER -- requirements
Module: di_line_prefetcher

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0080, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, line FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_OUTST, default 2, max outstanding memory requests.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port branch_i  in  1  redirect request.
REQ-007 SHALL have port branch_addr_i  in  32  redirect target, halfword aligned.
REQ-008 SHALL have port instr_req_o  out  1  memory request.
REQ-009 SHALL have port instr_addr_o  out  32  request address, 16B aligned.
REQ-010 SHALL have port instr_gnt_i  in  1  request accepted.
REQ-011 SHALL have port instr_rvalid_i  in  1  response valid, in order.
REQ-012 SHALL have port instr_rdata_i  in  128  response line.
REQ-013 SHALL have port instr_buf_o  out  128  merged line view to issue fetchers.
REQ-014 SHALL have port pi_hw_idx_o  out  3  primary halfword index.
REQ-015 SHALL have port pi_hw_idx_valid_o  out  1  primary instruction fully present.
REQ-016 SHALL have port pi_fetch_addr_o  out  32  primary instruction address.
REQ-017 SHALL have port advance_i  in  1  IF consumes primary (plus issue2 if allocated).
REQ-018 SHALL have port next_hw_idx_i  in  3  halfword index after consumption.

Function
REQ-019 SHALL keep cur (FIFO head) and nxt (head+1) lines; instr_buf_o halfword k = cur[k] if k>=pi_hw_idx_o, else nxt[k] (zero if nxt absent).
REQ-020 SHALL drive pi_hw_idx_valid_o = cur present AND NOT (pi_hw_idx_o==7 AND cur[7][1:0]==2'b11 AND nxt absent).
REQ-021 SHALL drive pi_fetch_addr_o = {cur_line_addr[31:4], pi_hw_idx_o, 1'b0}.
REQ-022 SHALL on advance_i & pi_hw_idx_valid_o load pi_hw_idx_o <= next_hw_idx_i; advance_i with valid low is ignored.
REQ-023 SHALL detect line wrap as next_hw_idx_i < pi_hw_idx_o (consumption 1..4 halfwords); on wrap pop FIFO and add 16 to cur_line_addr in the same cycle.
REQ-024 SHALL assert instr_req_o in RUN while occupancy + outstanding < DEPTH and outstanding < MAX_OUTST; req and addr held stable until gnt.
REQ-025 SHALL add 16 to the request address on each gnt; outstanding +1 on gnt, -1 on rvalid, both same cycle = unchanged.
REQ-026 SHALL push instr_rdata_i on rvalid in RUN; in DRAIN discard it; no push on a full FIFO (guaranteed by REQ-024; assertion).
REQ-027 SHALL implement FSM states RUN and DRAIN: branch_i with outstanding>0 (after this cycle's gnt/rvalid) -> DRAIN; DRAIN with outstanding==0 -> RUN; branch_i with outstanding==0 -> stay or go RUN.
REQ-028 SHALL on branch_i flush FIFO, set request and cur line address to branch_addr_i[31:4]<<4, set pi_hw_idx_o to branch_addr_i[3:1]; pi_hw_idx_valid_o low the next cycle.
REQ-029 SHALL give branch_i priority over advance_i and over push in the same cycle; a gnt in the branch cycle counts as outstanding to be discarded.
REQ-030 SHALL deassert instr_req_o in DRAIN; a request held ungranted when branch_i occurs is withdrawn (memory side tolerates withdrawal).
REQ-031 SHALL wrap 32-bit addresses modulo 2^32 with no error.
REQ-032 SHALL have latency rvalid-to-pi_hw_idx_valid_o of one cycle (registered push).

Reset
REQ-033 SHALL on rst: FIFO empty, outstanding 0, state RUN, request/cur line address BOOT_ADDR[31:4]<<4, pi_hw_idx_o BOOT_ADDR[3:1], instr_req_o 0 that cycle, pi_hw_idx_valid_o 0, instr_buf_o 0, pi_fetch_addr_o = BOOT_ADDR.
REQ-034 SHALL ignore responses for pre-reset requests arriving after reset (bench precondition: memory reset together).

Structure
REQ-035 SHALL place DI_LINE_W=128, DI_HW_PER_LINE=8, and the RUN/DRAIN state enum in shared package di_pkg.
REQ-036 SHALL implement storage as sub-module di_line_fifo (DEPTH x 128 plus 28-bit line address, push/pop/flush, head and head+1 read ports).

Verification
REQ-037 SHALL cover: reset, BOOT_ADDR=0x80, gnt always, rvalid 1 cycle later -> instr_addr_o 0x80 then 0x90; pi_hw_idx_valid_o high 2 cycles after first gnt, pi_fetch_addr_o 0x80.
REQ-038 SHALL cover: pi_hw_idx=6, advance with next_hw_idx_i=1 -> FIFO pop, pi_fetch_addr_o = line+16+2, instr_buf_o shows new head.
REQ-039 SHALL cover: uncompressed instr at hw 7, nxt absent -> valid 0; nxt arrives -> valid 1, instr_buf_o[15:0] = nxt hw0.
REQ-040 SHALL cover: branch to 0x1006 with 2 outstanding -> DRAIN, both responses dropped, then request 0x1000, pi_hw_idx_o=3.
REQ-041 SHALL cover: gnt held low 5 cycles -> instr_req_o and instr_addr_o stable; FIFO full with no advance -> no request.
REQ-042 SHALL cover: branch_i, advance_i and rvalid in one cycle -> branch wins, FIFO empty, response discarded.
